// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the reaction-game datapath. Both this elapsed-time
// counter and the downstream BCD decoder use these constants.
//   - game_state_t : encoding of the 2-bit game FSM state bus
//   - bcd_t        : one 4-bit BCD digit
//   - BCD_MAX      : largest legal BCD digit value
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10,
        ST_STOP = 2'b11
    } game_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One decade (0-9) counter stage of the elapsed-time chain.
// Ports:
//   clk       in  1  clock, rising edge
//   rst_n     in  1  asynchronous active-low reset, clears q
//   clr       in  1  synchronous clear, wins over counting
//   hold      in  1  suppresses the increment while still reporting carry
//   en        in  1  count enable / carry in from the less significant digit
//   q         out 4  BCD digit value, always 0-9
//   carry_out out 1  en & (q == 9): this digit wraps on the current tick
module bcd_digit
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       hold,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry_out
);

    // Carry is purely combinational so the whole chain settles within one
    // cycle; it ignores hold so the top can detect "all nines" through it.
    assign carry_out = en && (q == BCD_MAX);

    // Only ever loads 0 or q+1 with q<9, so values above 9 cannot arise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !hold) begin
            q <= (q == BCD_MAX) ? 4'd0 : 4'(q + 4'd1);
        end
    end

endmodule

// File: rtl/bcd_reaction_counter.sv
// bcd_reaction_counter
// Four-digit BCD elapsed-time counter (s.tenths hundredths ms) for the
// reaction game. Counts 1 ms ticks while the game FSM is counting, freezes
// when stopped or idle, and clears while armed.
// Parameters:
//   TICK_DIV  clock cycles per 1 ms tick (>= 2)
//   PW        prescaler width, 2**PW > TICK_DIV
// Ports:
//   Clk      in  1  system clock
//   Resetn   in  1  asynchronous active-low reset
//   state    in  2  game FSM state (00 idle, 01 armed, 10 counting, 11 stopped)
//   S        out 4  seconds digit
//   tS       out 4  tenths digit
//   hS       out 4  hundredths digit
//   mS       out 4  milliseconds digit
//   running  out 1  registered "counting" indicator
//   ovf      out 1  saturation flag
// Build option:
//   SAT_COUNTER_EN  defined: 9.999 saturates and sets a sticky ovf.
//                   undefined: 9.999 wraps to 0.000 and ovf is tied low.
module bcd_reaction_counter
    import game_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int PW       = 16
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic [1:0] state,
    output logic [3:0] S,
    output logic [3:0] tS,
    output logic [3:0] hS,
    output logic [3:0] mS,
    output logic       running,
    output logic       ovf
);

`ifdef SAT_COUNTER_EN
    localparam logic SAT_ON = 1'b1;
`else
    localparam logic SAT_ON = 1'b0;
`endif

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    game_state_t   cur_state;
    logic          is_run;
    logic          is_arm;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic          freeze;
    logic          ms_carry;
    logic          hs_carry;
    logic          ts_carry;
    logic          s_carry;
    bcd_t          ms_q;
    bcd_t          hs_q;
    bcd_t          ts_q;
    bcd_t          s_q;

    assign cur_state = game_state_t'(state);
    assign is_run    = (cur_state == ST_RUN);
    assign is_arm    = (cur_state == ST_ARM);

    // Tick is gated by the sampled state, so a tick landing on the edge
    // where the state has already become "stopped" is dropped.
    assign tick = is_run && (prescaler == TICK_LAST);

    // Prescaler runs only while counting; in idle/stopped it keeps its
    // partial count so a direct stop->run resumes mid-millisecond.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            prescaler <= '0;
        end else if (is_arm) begin
            prescaler <= '0;
        end else if (is_run) begin
            prescaler <= tick ? '0 : PW'(prescaler + 1'b1);
        end
    end

    // running is one edge late relative to the state input by design.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            running <= 1'b0;
        end else begin
            running <= is_run;
        end
    end

    // s_carry means "9.999 and a tick is arriving"; in saturating builds
    // that blocks every digit so the display sticks at 9.999.
    assign freeze = SAT_ON && s_carry;

    bcd_digit u_ms (
        .clk       (Clk),
        .rst_n     (Resetn),
        .clr       (is_arm),
        .hold      (freeze),
        .en        (tick),
        .q         (ms_q),
        .carry_out (ms_carry)
    );

    bcd_digit u_hs (
        .clk       (Clk),
        .rst_n     (Resetn),
        .clr       (is_arm),
        .hold      (freeze),
        .en        (ms_carry),
        .q         (hs_q),
        .carry_out (hs_carry)
    );

    bcd_digit u_ts (
        .clk       (Clk),
        .rst_n     (Resetn),
        .clr       (is_arm),
        .hold      (freeze),
        .en        (hs_carry),
        .q         (ts_q),
        .carry_out (ts_carry)
    );

    bcd_digit u_s (
        .clk       (Clk),
        .rst_n     (Resetn),
        .clr       (is_arm),
        .hold      (freeze),
        .en        (ts_carry),
        .q         (s_q),
        .carry_out (s_carry)
    );

    assign mS = ms_q;
    assign hS = hs_q;
    assign tS = ts_q;
    assign S  = s_q;

`ifdef SAT_COUNTER_EN
    logic ovf_q;

    // Sticky until the next arm or reset.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ovf_q <= 1'b0;
        end else if (is_arm) begin
            ovf_q <= 1'b0;
        end else if (freeze) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_reaction_counter.sv
// tb_bcd_reaction_counter
// Directed bench for bcd_reaction_counter with TICK_DIV=4. Inputs change and
// outputs are sampled on the falling clock edge. Build with SAT_COUNTER_EN
// defined to exercise the saturating variant.
module tb_bcd_reaction_counter;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ARM  = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] STOP = 2'b11;

`ifdef SAT_COUNTER_EN
    localparam logic [15:0] AFTER_OVF1 = 16'h9999;
    localparam logic [15:0] AFTER_OVF2 = 16'h9999;
    localparam logic [15:0] OVF_EXP    = 16'd1;
`else
    localparam logic [15:0] AFTER_OVF1 = 16'h0000;
    localparam logic [15:0] AFTER_OVF2 = 16'h0001;
    localparam logic [15:0] OVF_EXP    = 16'd0;
`endif

    logic       Clk    = 1'b0;
    logic       Resetn = 1'b1;
    logic [1:0] state  = IDLE;
    logic [3:0] S;
    logic [3:0] tS;
    logic [3:0] hS;
    logic [3:0] mS;
    logic       running;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    bcd_reaction_counter #(
        .TICK_DIV (4),
        .PW       (4)
    ) dut (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .state   (state),
        .S       (S),
        .tS      (tS),
        .hS      (hS),
        .mS      (mS),
        .running (running),
        .ovf     (ovf)
    );

    always #5 Clk = ~Clk;

    // Drive a state and let the given number of rising edges pass,
    // returning on a falling edge so outputs are stable for sampling.
    task automatic applyStimulus(input logic [1:0] st, input int cycles);
        state = st;
        repeat (cycles) @(negedge Clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] digits();
        return {S, tS, hS, mS};
    endfunction

    initial begin
        // Asynchronous reset before any clock edge.
        #2 Resetn = 1'b0;
        #1;
        checkOutput("reset_digits",  digits(),          16'h0000);
        checkOutput("reset_running", {15'd0, running},  16'd0);
        checkOutput("reset_ovf",     {15'd0, ovf},      16'd0);

        @(negedge Clk);
        state = ARM;
        @(negedge Clk);
        Resetn = 1'b1;

        applyStimulus(ARM, 2);
        checkOutput("arm_clear", digits(), 16'h0000);

        // First edge in run: running rises, no tick yet.
        applyStimulus(RUN, 1);
        checkOutput("run_running", {15'd0, running}, 16'd1);
        checkOutput("run_first",   digits(),         16'h0000);

        applyStimulus(RUN, 35);
        checkOutput("tick9",  digits(), 16'h0009);
        applyStimulus(RUN, 4);
        checkOutput("tick10", digits(), 16'h0010);

        // Walk to 0.999 then confirm the full carry resolves on one edge.
        applyStimulus(RUN, 3956);
        checkOutput("at_0999",     digits(), 16'h0999);
        applyStimulus(RUN, 3);
        checkOutput("pre_carry",   digits(), 16'h0999);
        applyStimulus(RUN, 1);
        checkOutput("carry_chain", digits(), 16'h1000);

        // Prescaler reaches 3: the tick would land on the next edge, but
        // the state is stopped by then.
        applyStimulus(RUN, 3);
        applyStimulus(STOP, 1);
        checkOutput("stop_running", {15'd0, running}, 16'd0);
        checkOutput("stop_no_tick", digits(),          16'h1000);
        applyStimulus(STOP, 19);
        checkOutput("stop_frozen",  digits(),          16'h1000);

        // Resume directly: held prescaler gives an immediate tick.
        applyStimulus(RUN, 1);
        checkOutput("resume_tick", digits(), 16'h1001);

        applyStimulus(STOP, 1);
        applyStimulus(ARM, 1);
        checkOutput("rearm_clear",   digits(),          16'h0000);
        checkOutput("rearm_running", {15'd0, running},  16'd0);

        // Count all the way to 9.999 and beyond.
        applyStimulus(RUN, 39996);
        checkOutput("at_9999",  digits(),     16'h9999);
        checkOutput("ovf_pre",  {15'd0, ovf}, 16'd0);
        applyStimulus(RUN, 4);
        checkOutput("past_9999", digits(),    AFTER_OVF1);
        checkOutput("ovf_set",  {15'd0, ovf}, OVF_EXP);
        applyStimulus(RUN, 4);
        checkOutput("past_9999_2", digits(),  AFTER_OVF2);

        // Idle keeps the last result on display.
        applyStimulus(IDLE, 100);
        checkOutput("idle_hold",    digits(),          AFTER_OVF2);
        checkOutput("idle_running", {15'd0, running},  16'd0);
        checkOutput("idle_ovf",     {15'd0, ovf},      OVF_EXP);

        applyStimulus(ARM, 1);
        checkOutput("arm_ovf_clr", {15'd0, ovf}, 16'd0);
        checkOutput("arm_digits",  digits(),     16'h0000);

        // Reset in the middle of a count clears without waiting for Clk.
        applyStimulus(RUN, 8);
        checkOutput("pre_reset", digits(), 16'h0002);
        Resetn = 1'b0;
        #1;
        checkOutput("midrun_reset_digits",  digits(),          16'h0000);
        checkOutput("midrun_reset_running", {15'd0, running},  16'd0);
        @(negedge Clk);
        Resetn = 1'b1;
        applyStimulus(RUN, 1);
        checkOutput("post_reset_running", {15'd0, running}, 16'd1);
        applyStimulus(RUN, 3);
        checkOutput("post_reset_count",   digits(),         16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
